uart_tx_engine: RTL and testbench

Parametrised UART transmit engine: buffers characters in a small FIFO and serialises each one onto a single tx line as a start bit, data bits, an optional parity bit and stop bits. Every frame setting is chosen at runtime: character length 5–8, parity off/even/odd, stop bits 1/1.5/2, oversampling 2/4/6/8, baud divisor, and LSB/MSB order. It is the synthesizable DUT-side counterpart to the UART AVIP transmit agent. Its cfg encodings match the AVIP globals enums, so one configuration drives both.

---
 rtl/uart_tx_engine.sv | 202 ++++++++++++++++++++
 tb/tb_uart_tx_engine.sv | 290 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_engine.sv
// UART transmit engine: a small character FIFO feeding a runtime-configurable
// serialiser (5-8 data bits, optional parity, 1/1.5/2 stop bits, MSB/LSB first).
module uart_tx_engine #(
   parameter int CHAR_LENGTH = 8,
   parameter int FIFO_DEPTH  = 4,
   parameter int DIV_WIDTH   = 16
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic [DIV_WIDTH-1:0]          cfg_baud_div,
   input  logic [3:0]                    cfg_oversampling,
   input  logic [3:0]                    cfg_uart_type,
   input  logic                          cfg_parity_en,
   input  logic                          cfg_parity_odd,
   input  logic [1:0]                    cfg_stop_bit,
   input  logic                          cfg_msb_first,
   input  logic                          s_valid,
   output logic                          s_ready,
   input  logic [CHAR_LENGTH-1:0]        s_data,
   output logic                          tx,
   output logic                          busy,
   output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
   output logic                          frame_done
);

   localparam int AW = $clog2(FIFO_DEPTH);
   localparam int CW = AW + 1;

   typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

   logic [CHAR_LENGTH-1:0] mem_q [FIFO_DEPTH];
   logic [AW-1:0]          wr_ptr_q, rd_ptr_q;
   logic [CW-1:0]          count_q;
   logic                   push, pop;

   state_t                 state_q, state_d;
   logic [DIV_WIDTH-1:0]   tick_q, div_q;
   logic [4:0]             sub_q, stop_q, limit;
   logic [3:0]             bit_q, n_q, os_q;
   logic [CHAR_LENGTH-1:0] sh_q;
   logic                   par_en_q, par_bit_q, msb_q;
   logic                   tx_q, tx_d, busy_q, done_pend_q, frame_done_q;
   logic                   tick, bit_end, start_frame, stop_end, can_start;

   logic [DIV_WIDTH-1:0]   div_eff;
   logic [3:0]             os_eff, n_eff;
   logic [4:0]             stop_eff;
   logic [CHAR_LENGTH-1:0] rd_data, s_masked, s_aligned;

   assign s_ready    = (count_q < CW'(FIFO_DEPTH));
   assign push       = s_valid && s_ready;
   assign rd_data    = mem_q[rd_ptr_q];
   assign fifo_count = count_q;
   assign tx         = tx_q;
   assign busy       = busy_q;
   assign frame_done = frame_done_q;
   assign can_start  = (count_q != '0) && (cfg_uart_type != 4'd0);

   always_ff @(posedge clk) begin
      if (push) mem_q[wr_ptr_q] <= s_data;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
         if (pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
         if (push && !pop)      count_q <= count_q + CW'(1);
         else if (pop && !push) count_q <= count_q - CW'(1);
      end
   end

   // Sanitise the live configuration; it is only captured on a frame start.
   always_comb begin
      div_eff = (cfg_baud_div == '0) ? DIV_WIDTH'(1) : cfg_baud_div;
      case (cfg_oversampling)
         4'd4, 4'd6, 4'd8: os_eff = cfg_oversampling;
         default:          os_eff = 4'd2;
      endcase
      case (cfg_uart_type)
         4'd5, 4'd6, 4'd7, 4'd8: n_eff = cfg_uart_type;
         default:                n_eff = 4'd8;
      endcase
      if (int'(n_eff) > CHAR_LENGTH) n_eff = 4'(CHAR_LENGTH);
      case (cfg_stop_bit)
         2'd0:    stop_eff = {1'b0, os_eff} + {2'b00, os_eff[3:1]};
         2'd2:    stop_eff = {os_eff, 1'b0};
         default: stop_eff = {1'b0, os_eff};
      endcase
      for (int i = 0; i < CHAR_LENGTH; i++) begin
         s_masked[i] = rd_data[i] & (i < int'(n_eff));
      end
      // MSB-first frames are left-aligned so the shifter always sends its top bit.
      s_aligned = s_masked << (CHAR_LENGTH - int'(n_eff));
   end

   assign limit   = (state_q == STOP) ? stop_q : {1'b0, os_q};
   assign tick    = (tick_q == div_q - DIV_WIDTH'(1));
   assign bit_end = tick && (sub_q == limit - 5'd1);

   always_comb begin
      state_d     = state_q;
      pop         = 1'b0;
      start_frame = 1'b0;
      stop_end    = 1'b0;
      tx_d        = 1'b1;
      case (state_q)
         IDLE: begin
            if (can_start) begin
               pop         = 1'b1;
               start_frame = 1'b1;
               state_d     = START;
            end
         end
         START: begin
            tx_d = 1'b0;
            if (bit_end) state_d = DATA;
         end
         DATA: begin
            tx_d = msb_q ? sh_q[CHAR_LENGTH-1] : sh_q[0];
            if (bit_end && (bit_q == n_q - 4'd1)) state_d = par_en_q ? PARITY : STOP;
         end
         PARITY: begin
            tx_d = par_bit_q;
            if (bit_end) state_d = STOP;
         end
         STOP: begin
            if (bit_end) begin
               stop_end = 1'b1;
               if (can_start) begin
                  pop         = 1'b1;
                  start_frame = 1'b1;
                  state_d     = START;
               end else begin
                  state_d = IDLE;
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // Line outputs lag the state by one register so tx, busy and frame_done align.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= IDLE;
         tick_q       <= '0;
         sub_q        <= '0;
         bit_q        <= '0;
         div_q        <= DIV_WIDTH'(1);
         os_q         <= 4'd2;
         n_q          <= 4'd8;
         stop_q       <= 5'd2;
         par_en_q     <= 1'b0;
         par_bit_q    <= 1'b0;
         msb_q        <= 1'b0;
         sh_q         <= '0;
         tx_q         <= 1'b1;
         busy_q       <= 1'b0;
         done_pend_q  <= 1'b0;
         frame_done_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         tx_q         <= tx_d;
         busy_q       <= (state_q != IDLE);
         done_pend_q  <= stop_end;
         frame_done_q <= done_pend_q;
         if (start_frame) begin
            tick_q    <= '0;
            sub_q     <= '0;
            bit_q     <= '0;
            div_q     <= div_eff;
            os_q      <= os_eff;
            n_q       <= n_eff;
            stop_q    <= stop_eff;
            par_en_q  <= cfg_parity_en;
            par_bit_q <= (^s_masked) ^ cfg_parity_odd;
            msb_q     <= cfg_msb_first;
            sh_q      <= cfg_msb_first ? s_aligned : s_masked;
         end else if (state_q != IDLE) begin
            if (tick) begin
               tick_q <= '0;
               if (bit_end) begin
                  sub_q <= '0;
                  if (state_q == DATA) begin
                     bit_q <= bit_q + 4'd1;
                     sh_q  <= msb_q ? (sh_q << 1) : (sh_q >> 1);
                  end
               end else begin
                  sub_q <= sub_q + 5'd1;
               end
            end else begin
               tick_q <= tick_q + DIV_WIDTH'(1);
            end
         end
      end
   end

endmodule

// File: tb/tb_uart_tx_engine.sv
// Scoreboarded bench for uart_tx_engine: stimulus queues hand-written frame
// waveforms, a monitor process matches them against the serial line.
module tb_uart_tx_engine;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [15:0] cfg_baud_div;
   logic [3:0]  cfg_oversampling, cfg_uart_type;
   logic        cfg_parity_en, cfg_parity_odd, cfg_msb_first;
   logic [1:0]  cfg_stop_bit;
   logic        s_valid, s_ready;
   logic [7:0]  s_data;
   logic        tx, busy, frame_done;
   logic [2:0]  fifo_count;

   always #5 clk = ~clk;

   uart_tx_engine #(.CHAR_LENGTH(8), .FIFO_DEPTH(4), .DIV_WIDTH(16)) dut (
      .clk(clk), .rst(rst),
      .cfg_baud_div(cfg_baud_div), .cfg_oversampling(cfg_oversampling),
      .cfg_uart_type(cfg_uart_type), .cfg_parity_en(cfg_parity_en),
      .cfg_parity_odd(cfg_parity_odd), .cfg_stop_bit(cfg_stop_bit),
      .cfg_msb_first(cfg_msb_first), .s_valid(s_valid), .s_ready(s_ready),
      .s_data(s_data), .tx(tx), .busy(busy), .fifo_count(fifo_count),
      .frame_done(frame_done)
   );

   int checks = 0;
   int failures = 0;
   int done_seen = 0;
   int exp_done = 0;
   bit mon_busy = 0;

   // Expected frames: start+data+parity bits as '0'/'1' text, cycles per bit,
   // stop cycles, and whether the next frame must follow with no idle cycle.
   string exp_bits[$];
   string exp_name[$];
   int    exp_bc[$];
   int    exp_sc[$];
   bit    exp_b2b[$];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("FAIL %s actual=%0d required=%0d", name, act, req);
      end
   endtask

   task automatic expect_frame(input string bits, input int bc, input int sc,
                               input bit b2b, input string name, input bit completes);
      exp_bits.push_back(bits);
      exp_bc.push_back(bc);
      exp_sc.push_back(sc);
      exp_b2b.push_back(b2b);
      exp_name.push_back(name);
      if (completes) exp_done++;
   endtask

   task automatic cyc(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   // Called at posedge+1; the push lands on the next edge and returns at posedge+1.
   task automatic push(input logic [7:0] d, output bit acc);
      s_valid = 1'b1;
      s_data  = d;
      acc     = s_ready;
      @(posedge clk);
      #1;
      s_valid = 1'b0;
      $display("push data=%02h accepted=%0d fifo_count=%0d", d, acc, fifo_count);
   endtask

   task automatic set_cfg(input int div, input int os, input int typ, input bit pe,
                          input bit po, input int sb, input bit msb);
      cfg_baud_div     = 16'(div);
      cfg_oversampling = 4'(os);
      cfg_uart_type    = 4'(typ);
      cfg_parity_en    = pe;
      cfg_parity_odd   = po;
      cfg_stop_bit     = 2'(sb);
      cfg_msb_first    = msb;
   endtask

   task automatic drain(input string name);
      int n = 0;
      while ((exp_bits.size() != 0 || mon_busy) && n < 3000) begin
         @(negedge clk);
         n++;
      end
      check({name, "_drain_pending"}, exp_bits.size() + int'(mon_busy), 0);
      @(posedge clk);
      #1;
   endtask

   always @(negedge clk) if (frame_done === 1'b1) done_seen++;

   // Monitor: frames are recognised by a low tx; each one is checked cycle by cycle.
   initial begin : monitor
      string bits, nm;
      int bc, sc, nb, len, errs, bad_at, busy_errs, early_done;
      bit b2b, carry, aborted;
      logic eb;
      carry = 1'b0;
      forever begin
         if (!carry) begin
            @(negedge clk);
            if (rst !== 1'b0 || tx !== 1'b0) continue;
         end
         carry = 1'b0;
         if (exp_bits.size() == 0) begin
            check("unexpected_frame_start_tx", tx, 1);
            while (tx !== 1'b1) @(negedge clk);
            continue;
         end
         bits = exp_bits.pop_front();
         bc   = exp_bc.pop_front();
         sc   = exp_sc.pop_front();
         b2b  = exp_b2b.pop_front();
         nm   = exp_name.pop_front();
         mon_busy = 1'b1;
         nb = bits.len();
         len = nb * bc + sc;
         errs = 0; bad_at = -1; busy_errs = 0; early_done = 0; aborted = 1'b0;
         for (int k = 0; k < len; k++) begin
            if (k > 0) @(negedge clk);
            if (rst !== 1'b0) begin
               aborted = 1'b1;
               break;
            end
            eb = (k < nb * bc) ? (bits.getc(k / bc) == "1") : 1'b1;
            if (tx !== eb) begin
               errs++;
               if (bad_at < 0) bad_at = k;
            end
            if (busy !== 1'b1) busy_errs++;
            if (k > 0 && frame_done !== 1'b0) early_done++;
         end
         if (aborted) begin
            $display("frame %s aborted by reset", nm);
         end else begin
            check({nm, "_wave_bad_cycles"}, errs, 0);
            if (errs != 0) check({nm, "_first_bad_cycle"}, bad_at, -1);
            check({nm, "_busy_low_cycles"}, busy_errs, 0);
            check({nm, "_early_frame_done"}, early_done, 0);
            @(negedge clk);
            check({nm, "_frame_done"}, frame_done, 1);
            if (b2b) begin
               check({nm, "_b2b_next_start_tx"}, tx, 0);
               check({nm, "_b2b_busy"}, busy, 1);
               carry = (tx === 1'b0);
            end else begin
               check({nm, "_idle_tx"}, tx, 1);
               check({nm, "_idle_busy"}, busy, 0);
            end
            $display("frame %s len=%0d bad_cycles=%0d frame_done=%0d", nm, len, errs, frame_done);
         end
         mon_busy = 1'b0;
      end
   end

   initial begin : stim
      bit acc;
      int accepted, done_before;
      logic [7:0] d4[5];
      string w4[5];
      d4 = '{8'h01, 8'h80, 8'hFF, 8'h3C, 8'h99};
      w4 = '{"010000000", "000000001", "011111111", "000111100", "0"};
      s_valid = 1'b0;
      s_data  = 8'h00;
      set_cfg(1, 2, 8, 0, 0, 1, 0);
      rst = 1'b1;
      cyc(3);
      rst = 1'b0;
      @(negedge clk);
      check("reset_tx", tx, 1);
      check("reset_busy", busy, 0);
      check("reset_frame_done", frame_done, 0);
      check("reset_fifo_count", fifo_count, 0);
      check("reset_s_ready", s_ready, 1);
      cyc(1);

      // div=1 os=2, 0xA5 LSB first, plus first-frame latency
      expect_frame("010100101", 2, 2, 0, "a5_lsb", 1);
      push(8'hA5, acc);
      check("a5_accepted", acc, 1);
      @(negedge clk);
      check("lat_count_n1", fifo_count, 1);
      check("lat_tx_n1", tx, 1);
      @(negedge clk);
      check("lat_count_n2", fifo_count, 0);
      check("lat_busy_n2", busy, 0);
      @(negedge clk);
      check("lat_tx_n3", tx, 0);
      check("lat_busy_n3", busy, 1);
      drain("a5_lsb");

      // div=2 os=4, 7 bits MSB first, even then odd parity
      set_cfg(2, 4, 7, 1, 0, 1, 1);
      expect_frame("010110100", 8, 8, 0, "5a_even", 1);
      push(8'h5A, acc);
      drain("5a_even");
      cfg_parity_odd = 1'b1;
      expect_frame("010110101", 8, 8, 0, "5a_odd", 1);
      push(8'h5A, acc);
      drain("5a_odd");

      // div=3 os=8, 5 bits, three stop lengths
      set_cfg(3, 8, 5, 0, 0, 1, 0);
      expect_frame("011111", 24, 24, 0, "stop_one", 1);
      push(8'h1F, acc);
      drain("stop_one");
      cfg_stop_bit = 2'd0;
      expect_frame("011111", 24, 36, 0, "stop_onehalf", 1);
      push(8'h1F, acc);
      drain("stop_onehalf");
      cfg_stop_bit = 2'd2;
      expect_frame("011111", 24, 48, 0, "stop_two", 1);
      push(8'h1F, acc);
      drain("stop_two");

      // type 0 holds the engine; FIFO fills to 4, then frames run back-to-back
      set_cfg(1, 2, 0, 0, 0, 1, 0);
      accepted = 0;
      for (int i = 0; i < 5; i++) begin
         if (s_ready === 1'b1)
            expect_frame(w4[i], 2, 2, (i < 3), $sformatf("b2b_%0d", i), 1);
         push(d4[i], acc);
         if (acc) accepted++;
      end
      cyc(3);
      check("hold_accepted", accepted, 4);
      check("hold_fifo_count", fifo_count, 4);
      check("hold_s_ready", s_ready, 0);
      check("hold_tx", tx, 1);
      check("hold_busy", busy, 0);
      cfg_uart_type = 4'd8;
      drain("b2b");
      check("b2b_fifo_empty", fifo_count, 0);
      check("b2b_s_ready", s_ready, 1);

      // reset mid-DATA with two characters queued
      set_cfg(1, 2, 8, 0, 0, 1, 0);
      expect_frame("011001100", 2, 2, 0, "abort", 0);
      push(8'h33, acc);
      push(8'h44, acc);
      push(8'h55, acc);
      cyc(5);
      check("abort_queued", fifo_count, 2);
      check("abort_mid_frame_busy", busy, 1);
      done_before = done_seen;
      rst = 1'b1;
      cyc(1);
      rst = 1'b0;
      @(negedge clk);
      check("abort_tx", tx, 1);
      check("abort_busy", busy, 0);
      check("abort_fifo_count", fifo_count, 0);
      check("abort_frame_done", frame_done, 0);
      cyc(40);
      check("abort_no_done", done_seen, done_before);
      check("abort_still_idle", busy, 0);

      // div=0 and os=0 behave as div=1 os=2
      set_cfg(0, 0, 8, 0, 0, 1, 0);
      expect_frame("010100101", 2, 2, 0, "zero_cfg", 1);
      push(8'hA5, acc);
      drain("zero_cfg");

      // cfg change mid-frame only affects the following frame
      set_cfg(1, 2, 8, 0, 0, 1, 0);
      expect_frame("011110000", 2, 2, 1, "midchg_first", 1);
      push(8'h0F, acc);
      cyc(4);
      expect_frame("0101101", 8, 8, 0, "midchg_second", 1);
      push(8'h2D, acc);
      set_cfg(2, 4, 6, 0, 0, 1, 0);
      drain("midchg");

      cyc(5);
      check("frame_done_total", done_seen, exp_done);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
